// File: rtl/grid_game_model.sv
// grid_game_model
// N x N two-player board model (X and O) with a one-hot cursor, turn and
// score tracking, and a sequential line-scan win detector.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   up/down/left/right  cursor move pulses (wrap within row/column)
//   center              place the mover's mark under the cursor
//   restart             new game, scores kept
//   X, O                occupancy vectors, bit r*N+c = row r, column c
//   C                   one-hot cursor
//   turn                0 = X to move, 1 = O to move
//   busy                win scan in progress
//   game_over, winner   00 none, 01 X, 10 O, 11 draw
//   illegal             one-cycle pulse on placement onto an occupied cell
//   score_x, score_o    saturating win counters
module grid_game_model #(
    parameter int N       = 3,
    parameter int WIN_LEN = 3,
    parameter int CW      = $clog2(N*N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           up,
    input  logic           down,
    input  logic           left,
    input  logic           right,
    input  logic           center,
    input  logic           restart,
    output logic [N*N-1:0] X,
    output logic [N*N-1:0] O,
    output logic [N*N-1:0] C,
    output logic           turn,
    output logic           busy,
    output logic           game_over,
    output logic [1:0]     winner,
    output logic           illegal,
    output logic [3:0]     score_x,
    output logic [3:0]     score_o
);

    localparam int CELLS = N * N;
    localparam int CAND  = 4 * CELLS;
    localparam int KW    = $clog2(CAND);
    localparam int MW    = $clog2(CELLS + 1);
    localparam logic [CW-1:0]    CENTRE_IDX = CW'(CELLS / 2);
    localparam logic [CELLS-1:0] CENTRE_HOT = {{(CELLS-1){1'b0}}, 1'b1} << (CELLS / 2);

    typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

    state_t        state;
    logic [CW-1:0] curIdx;
    logic [CW-1:0] nextIdx;
    logic [KW-1:0] scanIdx;
    logic [MW-1:0] moveCount;
    logic          hit;
    logic          candHit;

    // Cursor step with wrap-around; priority up > down > left > right.
    function automatic logic [CW-1:0] stepCursor(input logic [CW-1:0] idx,
                                                 input logic u, input logic d,
                                                 input logic l, input logic r);
        int row;
        int col;
        row = int'(idx) / N;
        col = int'(idx) % N;
        if (u)      row = (row == 0)     ? N - 1 : row - 1;
        else if (d) row = (row == N - 1) ? 0     : row + 1;
        else if (l) col = (col == 0)     ? N - 1 : col - 1;
        else if (r) col = (col == N - 1) ? 0     : col + 1;
        return CW'(row * N + col);
    endfunction

    function automatic logic [CELLS-1:0] oneHot(input logic [CW-1:0] idx);
        logic [CELLS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] satInc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    assign nextIdx = stepCursor(curIdx, up, down, left, right);

    // Candidate scanIdx: start cell scanIdx/4, direction scanIdx%4
    // (0 right, 1 down, 2 down-right, 3 down-left). Only the mover's
    // board is examined; the board cannot change while scanning.
    always_comb begin
        int s;
        int row;
        int col;
        int dir;
        int rr;
        int cc;
        logic valid;
        logic [CELLS-1:0] board;
        board = turn ? O : X;
        s     = int'(scanIdx) / 4;
        dir   = int'(scanIdx) % 4;
        row   = s / N;
        col   = s % N;
        rr    = 0;
        cc    = 0;
        case (dir)
            0:       valid = (col + WIN_LEN <= N);
            1:       valid = (row + WIN_LEN <= N);
            2:       valid = (col + WIN_LEN <= N) && (row + WIN_LEN <= N);
            default: valid = (row + WIN_LEN <= N) && (col >= WIN_LEN - 1);
        endcase
        candHit = valid;
        for (int i = 0; i < WIN_LEN; i++) begin
            rr = (dir == 0) ? row : row + i;
            cc = (dir == 1) ? col : ((dir == 3) ? col - i : col + i);
            if (valid && !board[CW'(rr * N + cc)]) candHit = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= PLAY;
            X         <= '0;
            O         <= '0;
            curIdx    <= CENTRE_IDX;
            C         <= CENTRE_HOT;
            turn      <= 1'b0;
            busy      <= 1'b0;
            game_over <= 1'b0;
            winner    <= 2'b00;
            illegal   <= 1'b0;
            score_x   <= 4'd0;
            score_o   <= 4'd0;
            scanIdx   <= '0;
            moveCount <= '0;
            hit       <= 1'b0;
        end else begin
            illegal <= 1'b0;
            // restart wins over any button, but the scan cannot be interrupted.
            if (restart && state != CHECK) begin
                state     <= PLAY;
                X         <= '0;
                O         <= '0;
                curIdx    <= CENTRE_IDX;
                C         <= CENTRE_HOT;
                turn      <= 1'b0;
                game_over <= 1'b0;
                winner    <= 2'b00;
                moveCount <= '0;
            end else begin
                case (state)
                    PLAY: begin
                        if (center) begin
                            if (X[curIdx] || O[curIdx]) begin
                                illegal <= 1'b1;
                            end else begin
                                if (turn) O[curIdx] <= 1'b1;
                                else      X[curIdx] <= 1'b1;
                                moveCount <= moveCount + MW'(1);
                                state     <= CHECK;
                                busy      <= 1'b1;
                                scanIdx   <= '0;
                                hit       <= 1'b0;
                            end
                        end else if (up || down || left || right) begin
                            curIdx <= nextIdx;
                            C      <= oneHot(nextIdx);
                        end
                    end
                    CHECK: begin
                        if (scanIdx == KW'(CAND - 1)) begin
                            // Last candidate folds straight into the decision.
                            busy <= 1'b0;
                            if (hit || candHit) begin
                                state     <= OVER;
                                game_over <= 1'b1;
                                winner    <= turn ? 2'b10 : 2'b01;
                                if (turn) score_o <= satInc(score_o);
                                else      score_x <= satInc(score_x);
                            end else if (moveCount == MW'(CELLS)) begin
                                state     <= OVER;
                                game_over <= 1'b1;
                                winner    <= 2'b11;
                            end else begin
                                state <= PLAY;
                                turn  <= ~turn;
                            end
                        end else begin
                            scanIdx <= scanIdx + KW'(1);
                            hit     <= hit || candHit;
                        end
                    end
                    default: begin
                        // OVER: everything frozen until restart or reset.
                    end
                endcase
            end
        end
    end

endmodule
